// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, requester IDs, address width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic REQ_ID_CPU = 1'b0;  // requester 0: processor
  localparam logic REQ_ID_DMA = 1'b1;  // requester 1: DMA / peripheral

  localparam int ADDR_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the memory and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: a requester holds REQx and its operands until GNTx pulses.
// Ports: REQx/RWx/ADDRx/WDATAx in, GNTx/DONEx out, RDATA out, ADDRESS/MEM_WDATA/
//        M_read/M_write out to memory, MEM_RDATA in from memory, BUSY out.
interface mem_arbiter_if #(
  parameter int DW = 8
);
  logic          REQ0, REQ1;
  logic          RW0, RW1;
  logic [7:0]    ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic          GNT0, GNT1;
  logic          DONE0, DONE1;
  logic [DW-1:0] RDATA;
  logic [7:0]    ADDRESS;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic          M_read, M_write;
  logic          BUSY;

  // Arbiter side.
  modport slave (
    input  REQ0, REQ1, RW0, RW1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
    output GNT0, GNT1, DONE0, DONE1, RDATA, ADDRESS, MEM_WDATA, M_read, M_write, BUSY
  );

  // Requesters plus memory model side.
  modport master (
    output REQ0, REQ1, RW0, RW1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
    input  GNT0, GNT1, DONE0, DONE1, RDATA, ADDRESS, MEM_WDATA, M_read, M_write, BUSY
  );
endinterface

// File: rtl/mem_arb_wait_cnt.sv
// Loadable 4-bit down-counter timing the memory access phase.
// Latency: last is combinational from the count register (high when count is 0).
// Backpressure: none; load wins over en, count stops at 0.
// Ports: clk, rst (sync, active-high), load/load_val, en, last.
module mem_arb_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       last
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign last = (cnt == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IDLE -> ACCESS (WAIT_CYCLES) -> DONE, registered outputs.
// Latency: REQ seen at edge k -> GNT in cycle k+1, DONE in cycle k+WAIT_CYCLES+1.
// Backpressure: requests are held by the requester until GNT; new ones wait in IDLE.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave).
// Params: WAIT_CYCLES (1..15), DW (data width).
// Macro MEM_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins ties;
//                              undefined -> round-robin, favouring requester 0 after reset.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DW          = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              state, state_nxt;
  logic                win_q, win_d;     // requester owning the current transfer
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DW-1:0]       wdat_q, wdat_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                busy_q, busy_d;
  logic                cnt_load, cnt_en, cnt_last;
  logic                any_req;
  logic                pick;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DW-1:0]       sel_wdata;

  assign any_req = bus.REQ0 | bus.REQ1;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick = bus.REQ0 ? REQ_ID_CPU : REQ_ID_DMA;
`else
  // Remembers who won last; a tie goes to the other requester.
  // Reset value DMA makes the first tie go to the CPU.
  logic last_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= REQ_ID_DMA;
    end else if ((state == IDLE) && any_req) begin
      last_gnt <= pick;
    end
  end

  assign pick = (bus.REQ0 && bus.REQ1) ? ~last_gnt :
                (bus.REQ1 ? REQ_ID_DMA : REQ_ID_CPU);
`endif

  assign sel_rw    = (pick == REQ_ID_DMA) ? bus.RW1    : bus.RW0;
  assign sel_addr  = (pick == REQ_ID_DMA) ? bus.ADDR1  : bus.ADDR0;
  assign sel_wdata = (pick == REQ_ID_DMA) ? bus.WDATA1 : bus.WDATA0;

  mem_arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .en       (cnt_en),
    .last     (cnt_last)
  );

  // Next-state and next-output logic; every output is a register loaded from here,
  // so strobes are set on entry to ACCESS and cleared on the edge leaving it.
  always_comb begin
    state_nxt = state;
    win_d     = win_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rdata_d   = rdata_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
          win_d     = pick;
          cnt_load  = 1'b1;
          gnt0_d    = (pick == REQ_ID_CPU);
          gnt1_d    = (pick == REQ_ID_DMA);
          rd_d      = ~sel_rw;
          wr_d      = sel_rw;
          addr_d    = sel_addr;
          wdat_d    = sel_wdata;
        end
      end
      ACCESS: begin
        if (cnt_last) begin
          state_nxt = DONE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          if (rd_q) begin
            rdata_d = bus.MEM_RDATA;
          end
          done0_d   = (win_q == REQ_ID_CPU);
          done1_d   = (win_q == REQ_ID_DMA);
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
      end
    endcase
    busy_d = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      win_q   <= REQ_ID_CPU;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      win_q   <= win_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.GNT0      = gnt0_q;
  assign bus.GNT1      = gnt1_q;
  assign bus.DONE0     = done0_q;
  assign bus.DONE1     = done1_q;
  assign bus.RDATA     = rdata_q;
  assign bus.ADDRESS   = addr_q;
  assign bus.MEM_WDATA = wdat_q;
  assign bus.M_read    = rd_q;
  assign bus.M_write   = wr_q;
  assign bus.BUSY      = busy_q;

endmodule
